// File: rtl/dmem_ahb_bridge.sv
// Data-side AHB-Lite master: turns one mem-stage RAM request into a single transfer and stalls the pipeline until it completes.
// Optional build macro DMEM_ERR_REPORT_EN: misalignment rejection, bus_err_o pulse and data-phase watchdog.
module dmem_ahb_bridge #(
  parameter logic [3:0] HPROT_VAL   = 4'b0001,
  parameter int         TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_addr_i,
  input  logic        ram_we_i,
  input  logic [2:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ce_i,
  output logic [31:0] ram_data_o,
  output logic        stall_req_o,
  output logic        bus_err_o,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  state_t      state, state_nx;
  logic [1:0]  htrans_nx;
  logic [31:0] haddr_nx, hwdata_nx, rdata_nx;
  logic        hwrite_nx;
  logic [2:0]  hsize_nx;
  logic        flush_q, flush_nx, drop;

  function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [2:0] sel);
    case (sel)
      3'b000:  lane_rep = {4{d[7:0]}};
      3'b001:  lane_rep = {2{d[15:0]}};
      default: lane_rep = d;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [2:0] sel);
    case (sel)
      3'b001:  align_addr = {a[31:1], 1'b0};
      3'b010:  align_addr = {a[31:2], 2'b00};
      default: align_addr = a;
    endcase
  endfunction

`ifdef DMEM_ERR_REPORT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  logic [WD_W-1:0] wd_cnt, wd_nx;
  logic            err_nx, err_q;

  function automatic logic misaligned(input logic [31:0] a, input logic [2:0] sel);
    misaligned = ((sel == 3'b001) && a[0]) || ((sel == 3'b010) && (a[1:0] != 2'b00));
  endfunction
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  assign hburst      = 3'b000;
  assign hprot       = HPROT_VAL;
  assign stall_req_o = ram_ce_i & (state != S_DONE);
  // A request withdrawn mid-transfer lets the bus finish but skips DONE.
  assign drop        = flush_q | ~ram_ce_i;

  always_comb begin
    state_nx  = state;
    htrans_nx = htrans;
    haddr_nx  = haddr;
    hwrite_nx = hwrite;
    hsize_nx  = hsize;
    hwdata_nx = hwdata;
    rdata_nx  = ram_data_o;
    flush_nx  = flush_q;
`ifdef DMEM_ERR_REPORT_EN
    err_nx    = 1'b0;
    wd_nx     = '0;
`endif
    case (state)
      S_IDLE: begin
        flush_nx = 1'b0;
        if (ram_ce_i) begin
          state_nx  = S_ADDR;
          htrans_nx = HT_NONSEQ;
          haddr_nx  = align_addr(ram_addr_i, ram_sel_i);
          hwrite_nx = ram_we_i;
          hsize_nx  = ram_sel_i;
`ifdef DMEM_ERR_REPORT_EN
          if (misaligned(ram_addr_i, ram_sel_i)) begin
            state_nx  = S_DONE;
            htrans_nx = HT_IDLE;
            err_nx    = 1'b1;
            rdata_nx  = '0;
          end
`endif
        end
      end
      S_ADDR: begin
        if (!ram_ce_i) flush_nx = 1'b1;
        if (hready) begin
          state_nx  = S_DATA;
          htrans_nx = HT_IDLE;
          hwdata_nx = lane_rep(ram_data_i, hsize);
        end
      end
      S_DATA: begin
        if (!ram_ce_i) flush_nx = 1'b1;
        if (hready) begin
          state_nx = drop ? S_IDLE : S_DONE;
          if (!drop) begin
            if (hresp)       rdata_nx = '0;
            else if (!hwrite) rdata_nx = hrdata;
`ifdef DMEM_ERR_REPORT_EN
            err_nx = hresp;
`endif
          end
        end
`ifdef DMEM_ERR_REPORT_EN
        else if (TIMEOUT_CYC != 0) begin
          if (wd_cnt == WD_LAST) begin
            state_nx = drop ? S_IDLE : S_DONE;
            if (!drop) begin
              err_nx   = 1'b1;
              rdata_nx = '0;
            end
          end else begin
            wd_nx = wd_cnt + 1'b1;
          end
        end
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      htrans     <= HT_IDLE;
      haddr      <= '0;
      hwrite     <= 1'b0;
      hsize      <= 3'b010;
      hwdata     <= '0;
      ram_data_o <= '0;
      flush_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      htrans     <= htrans_nx;
      haddr      <= haddr_nx;
      hwrite     <= hwrite_nx;
      hsize      <= hsize_nx;
      hwdata     <= hwdata_nx;
      ram_data_o <= rdata_nx;
      flush_q    <= flush_nx;
    end
  end

`ifdef DMEM_ERR_REPORT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q  <= 1'b0;
      wd_cnt <= '0;
    end else begin
      err_q  <= err_nx;
      wd_cnt <= wd_nx;
    end
  end
  assign bus_err_o = err_q;
`else
  assign bus_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_ahb_bridge.sv
// Directed bench for dmem_ahb_bridge: the bench plays the AHB slave and predicts each transfer at transaction level.
module tb_dmem_ahb_bridge;
  localparam int TO = 8;
`ifdef DMEM_ERR_REPORT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ram_addr_i, ram_data_i, ram_data_o, haddr, hwdata, hrdata;
  logic        ram_we_i, ram_ce_i, stall_req_o, bus_err_o, hwrite, hready, hresp;
  logic [2:0]  ram_sel_i, hsize, hburst;
  logic [1:0]  htrans;
  logic [3:0]  hprot;

  always #5 clk = ~clk;

  dmem_ahb_bridge #(.HPROT_VAL(4'b0001), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ram_addr_i(ram_addr_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_data_i(ram_data_i), .ram_ce_i(ram_ce_i), .ram_data_o(ram_data_o),
    .stall_req_o(stall_req_o), .bus_err_o(bus_err_o),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  int n_chk = 0, n_pass = 0;

  // expectations for the current cycle, consumed by the compare process
  bit          chk_on = 1'b0, chk_rst = 1'b0, chk_aph = 1'b0, chk_wd = 1'b0, chk_rd = 1'b0;
  bit          exp_stall, exp_err, exp_hwrite;
  logic [1:0]  exp_htrans;
  logic [2:0]  exp_hsize;
  logic [31:0] exp_haddr, exp_hwdata, exp_rdata;
  logic [31:0] model_rd;
  bit          rd_known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("stall_req", 32'(stall_req_o), 32'(exp_stall));
      check("htrans", 32'(htrans), 32'(exp_htrans));
      check("bus_err", 32'(bus_err_o), 32'(exp_err));
      if (chk_aph) begin
        check("haddr", haddr, exp_haddr);
        check("hwrite", 32'(hwrite), 32'(exp_hwrite));
        check("hsize", 32'(hsize), 32'(exp_hsize));
        check("hburst", 32'(hburst), 32'd0);
        check("hprot", 32'(hprot), 32'd1);
      end
      if (chk_wd) check("hwdata", hwdata, exp_hwdata);
      if (chk_rd) check("ram_data_o", ram_data_o, exp_rdata);
      if (chk_rst) begin
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwrite", 32'(hwrite), 32'd0);
        check("rst_hsize", 32'(hsize), 32'd2);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_ram_data_o", ram_data_o, 32'd0);
      end
    end
  end

  // One request from issue to one idle cycle after DONE; the bench answers as the slave.
  task automatic run_xfer(input logic [31:0] addr, input logic we, input logic [2:0] sel,
                          input logic [31:0] data, input int waits, input bit err,
                          input bit tmo, input logic [31:0] rdata, output int stalls);
    bit mis, issued, rd_chk;
    int last, bytes;
    logic [31:0] lane, rd_exp;
    mis    = (sel == 3'b001 && addr[0]) || (sel == 3'b010 && addr[1:0] != 2'b00);
    issued = !(EN && mis);
    last   = !issued ? 1 : (tmo ? 2 + TO : 3 + waits);
    bytes  = 1 << sel;
    case (sel)
      3'b000:  lane = {4{data[7:0]}};
      3'b001:  lane = {2{data[15:0]}};
      default: lane = data;
    endcase
    if (!issued) begin
      rd_chk = 1'b0; rd_exp = 32'd0; rd_known = 1'b0;
    end else if (err || tmo) begin
      rd_chk = 1'b1; rd_exp = 32'd0; rd_known = 1'b1;
    end else if (we) begin
      rd_chk = rd_known; rd_exp = model_rd;
    end else begin
      rd_chk = 1'b1; rd_exp = rdata; rd_known = 1'b1;
    end
    model_rd = rd_exp;
    stalls = 0;
    for (int k = 0; k <= last + 1; k++) begin
      @(posedge clk); #1;
      ram_ce_i = (k <= last); ram_addr_i = addr; ram_we_i = we; ram_sel_i = sel; ram_data_i = data;
      hready = 1'b1; hresp = 1'b0; hrdata = ~rdata;
      if (issued && k >= 2 && k < last) begin
        if (tmo || k < last - 1) hready = 1'b0;
        hresp = err;
        if (!tmo && k == last - 1) hrdata = rdata;
      end
      chk_on = 1'b1; chk_rst = 1'b0;
      exp_stall  = (k < last);
      exp_htrans = (issued && k == 1) ? 2'b10 : 2'b00;
      chk_aph    = issued && (k == 1);
      exp_haddr  = addr - (addr % 32'(bytes));
      exp_hwrite = we; exp_hsize = sel;
      chk_wd     = issued && we && k >= 2 && k < last;
      exp_hwdata = lane;
      exp_err    = (k == last) && EN && (err || tmo || !issued);
      chk_rd     = (k == last) && rd_chk;
      exp_rdata  = rd_exp;
      @(negedge clk);
      stalls += int'(stall_req_o);
    end
  endtask

  initial begin
    int st;
    rst = 1'b0; ram_ce_i = 1'b0; ram_addr_i = '0; ram_we_i = 1'b0; ram_sel_i = 3'b010;
    ram_data_i = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    model_rd = '0; rd_known = 1'b1;
    exp_stall = 1'b0; exp_htrans = 2'b00; exp_err = 1'b0;
    chk_on = 1'b1; chk_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; chk_rst = 1'b0;

    run_xfer(32'h0000_0100, 1'b0, 3'b010, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, st);
    check("lw_stall_cycles", 32'(st), 32'd3);
    check("lw_rdata", ram_data_o, 32'hDEAD_BEEF);

    run_xfer(32'h0000_0203, 1'b1, 3'b000, 32'h0000_00A5, 0, 1'b0, 1'b0, 32'h0, st);
    check("sb_stall_cycles", 32'(st), 32'd3);
    check("sb_hwdata", hwdata, 32'hA5A5_A5A5);
    check("sb_haddr", haddr, 32'h0000_0203);
    check("sb_rdata_kept", ram_data_o, 32'hDEAD_BEEF);

    run_xfer(32'h0000_0010, 1'b0, 3'b001, 32'h0, 2, 1'b0, 1'b0, 32'hCAFE_F00D, st);
    check("lh_stall_cycles", 32'(st), 32'd5);
    check("lh_rdata", ram_data_o, 32'hCAFE_F00D);

    run_xfer(32'h0000_0022, 1'b1, 3'b001, 32'h0000_1234, 0, 1'b0, 1'b0, 32'h0, st);
    check("sh_hwdata", hwdata, 32'h1234_1234);

    run_xfer(32'h0000_0300, 1'b1, 3'b010, 32'h7777_8888, 1, 1'b1, 1'b0, 32'h0, st);
    check("sw_err_stall_cycles", 32'(st), 32'd4);
    check("sw_err_rdata", ram_data_o, 32'h0);

    run_xfer(32'h0000_0102, 1'b0, 3'b010, 32'h0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, st);
`ifdef DMEM_ERR_REPORT_EN
    check("mis_stall_cycles", 32'(st), 32'd1);
`else
    check("mis_stall_cycles", 32'(st), 32'd3);
    check("mis_forced_haddr", haddr, 32'h0000_0100);
`endif

    run_xfer(32'h0000_0104, 1'b0, 3'b010, 32'h0, 0, 1'b0, 1'b0, 32'h1234_5678, st);

`ifdef DMEM_ERR_REPORT_EN
    run_xfer(32'h0000_0600, 1'b0, 3'b010, 32'h0, 0, 1'b0, 1'b1, 32'h55AA_55AA, st);
    check("tmo_stall_cycles", 32'(st), 32'(2 + TO));
`endif

    // flush: request withdrawn in the first data-phase cycle of a 2-wait load
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      ram_ce_i = (k <= 1); ram_addr_i = 32'h0000_0340; ram_we_i = 1'b0; ram_sel_i = 3'b010;
      hready = !(k == 2 || k == 3); hresp = 1'b0; hrdata = (k == 4) ? 32'h1111_2222 : 32'h0;
      exp_stall = (k <= 1); exp_htrans = (k == 1) ? 2'b10 : 2'b00;
      chk_aph = (k == 1); exp_haddr = 32'h0000_0340; exp_hwrite = 1'b0; exp_hsize = 3'b010;
      chk_wd = 1'b0; exp_err = 1'b0;
      chk_rd = (k >= 2) && rd_known; exp_rdata = model_rd;
      @(negedge clk);
    end

    // reset asserted during the data phase of a load
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      ram_addr_i = 32'h0000_0400; ram_we_i = 1'b0; ram_sel_i = 3'b010;
      ram_ce_i = (k <= 2); hready = (k != 2); hresp = 1'b0; hrdata = 32'h0;
      if (k == 3) rst = 1'b0;
      if (k == 5) rst = 1'b1;
      exp_stall = (k <= 2); exp_htrans = (k == 1) ? 2'b10 : 2'b00;
      chk_aph = (k == 1); exp_haddr = 32'h0000_0400; exp_hwrite = 1'b0; exp_hsize = 3'b010;
      chk_wd = 1'b0; chk_rd = 1'b0; exp_err = 1'b0;
      chk_rst = (k >= 3);
      @(negedge clk);
    end
    model_rd = '0; rd_known = 1'b1;

    run_xfer(32'h0000_0500, 1'b0, 3'b010, 32'h0, 0, 1'b0, 1'b0, 32'hA1B2_C3D4, st);
    check("post_rst_stall_cycles", 32'(st), 32'd3);
    check("post_rst_rdata", ram_data_o, 32'hA1B2_C3D4);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
